// File: rtl/glyph_stroke_seq.sv
// Multi-digit stroke sequencer: walks BCD digits through the stroke table
// and emits placed, scaled segments over a valid/ready handshake.
// Ports: clk/rst_n, start/abort, digits_in/n_digits/blank_lz/origin_x/y
//   tbl_sel/tbl_idx -> table, tbl_sx/sy/ex/ey/pen <- table
//   seg_valid/seg_ready, seg_sx/sy/ex/ey/pen, busy, done
module glyph_stroke_seq #(
  parameter int MAX_DIGITS  = 4,
  parameter int MAX_STROKES = 32,
  parameter int TBL_W       = 8,
  parameter int OUT_W       = 10,
  parameter int PITCH       = 40,
  parameter int SCALE_SHIFT = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [4*MAX_DIGITS-1:0]        digits_in,
  input  logic [$clog2(MAX_DIGITS+1)-1:0] n_digits,
  input  logic                           blank_lz,
  input  logic [OUT_W-1:0]               origin_x,
  input  logic [OUT_W-1:0]               origin_y,
  output logic [3:0]                     tbl_sel,
  output logic [$clog2(MAX_STROKES)-1:0] tbl_idx,
  input  logic [TBL_W-1:0]               tbl_sx,
  input  logic [TBL_W-1:0]               tbl_sy,
  input  logic [TBL_W-1:0]               tbl_ex,
  input  logic [TBL_W-1:0]               tbl_ey,
  input  logic                           tbl_pen,
  output logic                           seg_valid,
  input  logic                           seg_ready,
  output logic [OUT_W-1:0]               seg_sx,
  output logic [OUT_W-1:0]               seg_sy,
  output logic [OUT_W-1:0]               seg_ex,
  output logic [OUT_W-1:0]               seg_ey,
  output logic                           seg_pen,
  output logic                           busy,
  output logic                           done
);

  localparam int NW = $clog2(MAX_DIGITS+1);
  localparam int IW = $clog2(MAX_STROKES);
  localparam int CW = OUT_W + 4;
  localparam int DW = 4 * MAX_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EMIT,
    S_DONE
  } state_t;

  state_t            state;
  logic [DW-1:0]     dig_q;
  logic [NW-1:0]     n_q;
  logic              blz_q;
  logic [OUT_W-1:0]  ox_q;
  logic [OUT_W-1:0]  oy_q;
  logic [NW-1:0]     p_q;
  logic [IW:0]       idx_q;
  logic              lz_q;

  logic [NW-1:0]     n_cl;
  logic [NW-1:0]     p_nx;
  logic [IW:0]       idx_nx;
  logic [CW-1:0]     x_off;
  logic              entry_zero;
  logic              skip;
  logic              stroke_end;

  function automatic logic [3:0] pick(
    input logic [DW-1:0] d,
    input logic [NW-1:0] n,
    input logic [NW-1:0] pos
  );
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (pos < n && int'(n) - 1 - int'(pos) == i)
        r = d[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] place(
    input logic [OUT_W-1:0] o,
    input logic [TBL_W-1:0] t,
    input logic [CW-1:0]    off
  );
    logic [CW-1:0] s;
    s = CW'(o) + (CW'(t) << SCALE_SHIFT) + off;
    return (s > CW'({OUT_W{1'b1}})) ? '1 : s[OUT_W-1:0];
  endfunction

  assign n_cl = (int'(n_digits) > MAX_DIGITS) ?
                NW'(MAX_DIGITS) : n_digits;
  assign p_nx   = p_q + NW'(1);
  assign idx_nx = idx_q + (IW+1)'(1);
  assign x_off  = CW'(p_q) * CW'(PITCH << SCALE_SHIFT);

  assign entry_zero = (tbl_sx == '0) && (tbl_sy == '0) &&
                      (tbl_ex == '0) && (tbl_ey == '0) &&
                      !tbl_pen;
  // Leading zero: nothing nonzero seen yet and not the last position.
  assign skip = (tbl_sel > 4'd9) ||
                (blz_q && lz_q && tbl_sel == 4'd0 && p_nx < n_q);
  assign stroke_end = (idx_q == (IW+1)'(MAX_STROKES)) || entry_zero;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      dig_q     <= '0;
      n_q       <= '0;
      blz_q     <= 1'b0;
      ox_q      <= '0;
      oy_q      <= '0;
      p_q       <= '0;
      idx_q     <= '0;
      lz_q      <= 1'b0;
      tbl_sel   <= '0;
      tbl_idx   <= '0;
      seg_valid <= 1'b0;
      seg_sx    <= '0;
      seg_sy    <= '0;
      seg_ex    <= '0;
      seg_ey    <= '0;
      seg_pen   <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      seg_valid <= 1'b0;
      tbl_sel   <= '0;
      tbl_idx   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            dig_q   <= digits_in;
            n_q     <= n_cl;
            blz_q   <= blank_lz;
            ox_q    <= origin_x;
            oy_q    <= origin_y;
            p_q     <= '0;
            idx_q   <= '0;
            lz_q    <= 1'b1;
            tbl_idx <= '0;
            tbl_sel <= pick(digits_in, n_cl, '0);
            state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (p_q == n_q) begin
            tbl_sel <= '0;
            tbl_idx <= '0;
            state   <= S_DONE;
          end else if (skip || stroke_end) begin
            p_q     <= p_nx;
            idx_q   <= '0;
            tbl_idx <= '0;
            tbl_sel <= pick(dig_q, n_q, p_nx);
            if (tbl_sel != 4'd0)
              lz_q <= 1'b0;
          end else begin
            seg_sx    <= place(ox_q, tbl_sx, x_off);
            seg_sy    <= place(oy_q, tbl_sy, '0);
            seg_ex    <= place(ox_q, tbl_ex, x_off);
            seg_ey    <= place(oy_q, tbl_ey, '0);
            seg_pen   <= tbl_pen;
            seg_valid <= 1'b1;
            state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (seg_ready) begin
            seg_valid <= 1'b0;
            idx_q     <= idx_nx;
            tbl_idx   <= idx_nx[IW-1:0];
            state     <= S_FETCH;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glyph_stroke_seq.sv
// Testbench for glyph_stroke_seq: behavioural stroke table plus a
// queue-based reference of the expected segment stream and timing.
module tb_glyph_stroke_seq;

  localparam int MD    = 4;
  localparam int MS    = 32;
  localparam int PITCH = 40;
  localparam int SS    = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] digits_in;
  logic [2:0]  n_digits;
  logic        blank_lz;
  logic [9:0]  origin_x;
  logic [9:0]  origin_y;
  logic [3:0]  tbl_sel;
  logic [4:0]  tbl_idx;
  logic [7:0]  tbl_sx, tbl_sy, tbl_ex, tbl_ey;
  logic        tbl_pen;
  logic        seg_valid;
  logic        seg_ready;
  logic [9:0]  seg_sx, seg_sy, seg_ex, seg_ey;
  logic        seg_pen;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [9:0] sx;
    logic [9:0] sy;
    logic [9:0] ex;
    logic [9:0] ey;
    logic       pen;
  } seg_t;

  seg_t exp_q[$];
  seg_t rx_q[$];
  int   tests = 0;
  int   fails = 0;
  int   td, ti;

  always #5 clk = ~clk;

  glyph_stroke_seq #(
    .MAX_DIGITS(MD), .MAX_STROKES(MS), .TBL_W(8),
    .OUT_W(10), .PITCH(PITCH), .SCALE_SHIFT(SS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .digits_in(digits_in), .n_digits(n_digits),
    .blank_lz(blank_lz), .origin_x(origin_x), .origin_y(origin_y),
    .tbl_sel(tbl_sel), .tbl_idx(tbl_idx),
    .tbl_sx(tbl_sx), .tbl_sy(tbl_sy), .tbl_ex(tbl_ex), .tbl_ey(tbl_ey),
    .tbl_pen(tbl_pen),
    .seg_valid(seg_valid), .seg_ready(seg_ready),
    .seg_sx(seg_sx), .seg_sy(seg_sy), .seg_ex(seg_ex), .seg_ey(seg_ey),
    .seg_pen(seg_pen), .busy(busy), .done(done)
  );

  function automatic int n_str(input int d);
    return (d == 8) ? MS : (d % 5) + 1;
  endfunction
  function automatic int e_sx(input int d, input int i);
    return (d*17 + i*5) % 250 + 1;
  endfunction
  function automatic int e_sy(input int d, input int i);
    return (d*11 + i*7) % 250 + 2;
  endfunction
  function automatic int e_ex(input int d, input int i);
    return (d*3 + i*13) % 256;
  endfunction
  function automatic int e_ey(input int d, input int i);
    return (i*29 + d) % 256;
  endfunction
  function automatic int e_pen(input int d, input int i);
    return (i + d) % 2;
  endfunction

  always_comb begin
    td = int'(tbl_sel);
    ti = int'(tbl_idx);
    tbl_sx = '0; tbl_sy = '0; tbl_ex = '0; tbl_ey = '0;
    tbl_pen = 1'b0;
    if (td > 9) begin
      tbl_sx = 8'hAA; tbl_sy = 8'h55; tbl_ex = 8'h0F; tbl_ey = 8'hF0;
      tbl_pen = 1'b1;
    end else if (ti < n_str(td)) begin
      tbl_sx  = 8'(e_sx(td, ti));
      tbl_sy  = 8'(e_sy(td, ti));
      tbl_ex  = 8'(e_ex(td, ti));
      tbl_ey  = 8'(e_ey(td, ti));
      tbl_pen = 1'(e_pen(td, ti));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] pl(input int o, input int t,
                                    input int p);
    int v;
    v = o + (t << SS) + p * (PITCH << SS);
    return (v > 1023) ? 10'h3FF : 10'(v);
  endfunction

  task automatic build(input logic [15:0] dg, input int n,
                       input logic blz, input int ox, input int oy,
                       output int cyc);
    int  nn, d, k;
    bit  lz;
    seg_t s;
    exp_q.delete();
    nn  = (n > MD) ? MD : n;
    lz  = 1'b1;
    cyc = 1;
    for (int p = 0; p < nn; p++) begin
      d = int'((dg >> (4*(nn-1-p))) & 16'hF);
      if (d > 9 || (blz && lz && d == 0 && p < nn-1)) begin
        cyc += 1;
        if (d != 0) lz = 1'b0;
      end else begin
        if (d != 0) lz = 1'b0;
        k = n_str(d);
        for (int i = 0; i < k; i++) begin
          s.sx  = pl(ox, e_sx(d, i), p);
          s.sy  = pl(oy, e_sy(d, i), 0);
          s.ex  = pl(ox, e_ex(d, i), p);
          s.ey  = pl(oy, e_ey(d, i), 0);
          s.pen = 1'(e_pen(d, i));
          exp_q.push_back(s);
        end
        cyc += 2*k + 1;
      end
    end
  endtask

  // rmode: 0 ready high, 1 random ready, 2 ready low for 5 valid cycles
  task automatic run(input logic [15:0] dg, input logic [2:0] n,
                     input logic blz, input logic [9:0] ox,
                     input logic [9:0] oy, input int rmode,
                     input bit tchk);
    int   cyc, ndone, bp, nexp;
    bit   fin, held_v;
    seg_t cur, held;
    build(dg, int'(n), blz, int'(ox), int'(oy), cyc);
    nexp = exp_q.size();
    rx_q.delete();
    @(negedge clk);
    digits_in = dg; n_digits = n; blank_lz = blz;
    origin_x = ox; origin_y = oy; start = 1'b1;
    seg_ready = (rmode == 0);
    ndone = 0; bp = 0; fin = 1'b0; held_v = 1'b0; held = '0;
    for (int j = 0; j < 3000 && !fin; j++) begin
      @(negedge clk);
      cur = {seg_sx, seg_sy, seg_ex, seg_ey, seg_pen};
      if (held_v) begin
        chk("bp_valid", seg_valid, 1);
        chk("bp_hold", cur, held);
      end
      if (done) begin
        ndone++;
        if (tchk) chk("done_lat", j, cyc);
      end
      if (ndone > 0 && !done) begin
        chk("busy_after", busy, 0);
        fin = 1'b1;
      end
      if (seg_valid) bp++;
      unique case (rmode)
        0: seg_ready = 1'b1;
        1: seg_ready = 1'($urandom % 2);
        default: seg_ready = (bp > 5);
      endcase
      if (seg_valid && seg_ready) begin
        rx_q.push_back(cur);
        if (exp_q.size() > 0) chk("seg", cur, exp_q.pop_front());
        else chk("extra_seg", 1, 0);
      end
      held_v = seg_valid && !seg_ready;
      held   = cur;
      start  = busy && ($urandom % 3 == 0);
      digits_in = 16'($urandom);
    end
    start = 1'b0;
    if (!fin) chk("timeout", 0, 1);
    chk("done_cnt", ndone, 1);
    chk("seg_cnt", rx_q.size(), nexp);
  endtask

  initial begin
    int  w, ndone;
    bit  seen;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; digits_in = '0;
    n_digits = '0; blank_lz = 1'b0; origin_x = '0; origin_y = '0;
    seg_ready = 1'b0;
    #23;
    chk("rst_valid", seg_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tbl", {tbl_sel, tbl_idx}, 0);
    chk("rst_seg", {seg_sx, seg_sy, seg_ex, seg_ey, seg_pen}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(16'h0001, 3'd1, 1'b0, 10'd0, 10'd0, 0, 1'b1);
    chk("one_cnt", rx_q.size(), 2);
    chk("one_sx0", rx_q[0].sx, 18);
    chk("one_sx1", rx_q[1].sx, 23);

    run(16'h0123, 3'd3, 1'b0, 10'd10, 10'd20, 0, 1'b1);
    chk("place_x", rx_q[5].sx, 142);
    chk("place_y", rx_q[5].sy, 55);

    run(16'h0003, 3'd1, 1'b0, 10'd5, 10'd5, 2, 1'b0);

    run(16'h0070, 3'd4, 1'b1, 10'd0, 10'd0, 0, 1'b1);
    chk("blank_on", rx_q.size(), 4);
    run(16'h0070, 3'd4, 1'b0, 10'd0, 10'd0, 0, 1'b1);
    chk("blank_off", rx_q.size(), 6);

    run(16'h0001, 3'd1, 1'b0, 10'd1020, 10'd0, 0, 1'b1);
    chk("sat_sx", rx_q[0].sx, 10'h3FF);
    chk("sat_ex", rx_q[0].ex, 10'h3FF);
    chk("sat_sy", rx_q[0].sy, 13);

    run(16'h01A2, 3'd3, 1'b0, 10'd0, 10'd0, 0, 1'b1);
    chk("inv_cnt", rx_q.size(), 5);
    chk("inv_pos", rx_q[2].sx, 115);

    run(16'h0000, 3'd0, 1'b0, 10'd0, 10'd0, 0, 1'b1);
    run(16'h0008, 3'd1, 1'b0, 10'd3, 10'd4, 0, 1'b1);
    chk("max_str", rx_q.size(), 32);
    run(16'h4321, 3'd7, 1'b1, 10'd0, 10'd0, 0, 1'b1);

    @(negedge clk);
    digits_in = 16'h0033; n_digits = 3'd2; blank_lz = 1'b0;
    start = 1'b1; seg_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      seen = seg_valid;
    end
    chk("abort_pre", seen, 1);
    abort = 1'b1; seg_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; seg_ready = 1'b0;
    chk("abort_valid", seg_valid, 0);
    chk("abort_busy", busy, 0);
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_nodone", ndone, 0);

    @(negedge clk);
    digits_in = 16'h0008; n_digits = 3'd1; start = 1'b1; seg_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", seg_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_tbl", {tbl_sel, tbl_idx}, 0);
    chk("arst_seg", {seg_sx, seg_sy, seg_ex, seg_ey, seg_pen}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 25; r++) begin
      w = $urandom % 2;
      run(16'($urandom), 3'($urandom_range(0, 7)), 1'($urandom % 2),
          10'($urandom), 10'($urandom), w, w == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
